u_rx_fifo: RTL
==============

U_RX_FIFO -- requirements
Module: u_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving a FIFO depth of 2^DEPTH_LOG2 bytes (legal range 2..8).
REQ-002 SHALL have port sys_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rec_readyH  input  1  one-cycle strobe from the UART receiver: rec_dataH is valid this cycle.
REQ-005 SHALL have port rec_dataH  input  8  received byte.
REQ-006 SHALL have port recv_error  input  1  one-cycle receiver framing-error strobe.
REQ-007 SHALL have port rd_enH  input  1  consumer pops the head byte this cycle.
REQ-008 SHALL have port ovf_clrH  input  1  clears the sticky overflow flag.
REQ-009 SHALL have port rd_dataH  output  8  head byte, first-word-fall-through.
REQ-010 SHALL have port rd_validH  output  1  high when the FIFO is non-empty.
REQ-011 SHALL have port fullH  output  1  high when level equals 2^DEPTH_LOG2.
REQ-012 SHALL have port level  output  DEPTH_LOG2+1  number of stored bytes.
REQ-013 SHALL have port overflowH  output  1  sticky flag: a byte was dropped.
REQ-014 SHALL have ports err_clrH  input  1 and err_count  output  8, present only per REQ-031.

Function
REQ-015 SHALL implement storage as a 2^DEPTH_LOG2 x 8 array with write pointer, read pointer (DEPTH_LOG2 bits, wrapping modulo depth) and a separate level counter.
REQ-016 SHALL write rec_dataH at the write pointer and advance it when rec_readyH=1 and (fullH=0 or rd_enH=1).
REQ-017 SHALL present the byte at the read pointer on rd_dataH combinationally whenever rd_validH=1; a byte written in cycle N SHALL be visible on rd_dataH from cycle N+1 when the FIFO was empty.
REQ-018 SHALL advance the read pointer when rd_enH=1 and rd_validH=1; rd_enH while empty SHALL be ignored, with no pointer or level change.
REQ-019 SHALL update level per cycle as +1 for write only, -1 for read only, unchanged for simultaneous accepted write and read or neither.
REQ-020 SHALL, on simultaneous write and read while full, accept both: level stays at depth and overflowH is not set.
REQ-021 SHALL, on simultaneous write and read while empty, treat the read as ignored (REQ-018) and accept the write (level becomes 1).
REQ-022 SHALL drop rec_dataH and set overflowH on the next edge when rec_readyH=1, fullH=1 and rd_enH=0; stored contents and pointers SHALL remain unchanged.
REQ-023 SHALL hold overflowH until ovf_clrH=1; if a set condition and ovf_clrH coincide, overflowH SHALL be 1 afterwards.
REQ-024 SHALL not store any data on recv_error; recv_error affects only err_count.
REQ-025 SHALL derive rd_validH = (level != 0) and fullH = (level == 2^DEPTH_LOG2).
REQ-026 SHALL leave rd_dataH value unspecified while rd_validH=0.

Reset
REQ-027 SHALL, on sys_rst_n=0, immediately clear pointers, level, overflowH and err_count without waiting for a clock edge.
REQ-028 SHALL hold rd_validH=0, fullH=0, level=0 and overflowH=0 while in reset; array contents are not reset.
REQ-029 SHALL ignore all inputs while sys_rst_n=0; the first write is accepted on the first rising edge after deassertion.
REQ-030 SHALL discard any stored bytes when reset asserts mid-operation, so level=0 after reset.

Configuration
REQ-031 SHALL, with macro U_RX_FIFO_ERRCNT_EN defined, include err_clrH and err_count: an 8-bit counter incrementing on each recv_error strobe, saturating at 255, and cleared by err_clrH (clear wins over increment).
REQ-032 SHALL, without U_RX_FIFO_ERRCNT_EN, omit err_clrH and err_count ports and logic; recv_error SHALL remain an unused input.

Verification
REQ-033 SHALL cover: reset, write 0x41, 0x42 -> rd_validH=1, rd_dataH=0x41, level=2; pop -> rd_dataH=0x42, level=1.
REQ-034 SHALL cover: DEPTH_LOG2=4, write 17 bytes 0x00..0x10 with no reads -> fullH=1, level=16, overflowH=1, reads return 0x00..0x0F only.
REQ-035 SHALL cover: full FIFO, rec_readyH and rd_enH in the same cycle with 0xAA -> level stays 16, overflowH=0, 0xAA is read last.
REQ-036 SHALL cover: empty FIFO, rd_enH=1 for 3 cycles -> level=0, pointers unchanged; then write 0x55 -> rd_dataH=0x55 next cycle.
REQ-037 SHALL cover: level=5, assert sys_rst_n=0 between clock edges -> level=0 and rd_validH=0 immediately, before the next edge.
REQ-038 SHALL cover: with U_RX_FIFO_ERRCNT_EN, 260 recv_error strobes -> err_count=255; err_clrH together with recv_error -> err_count=0.

Source files
------------

// File: rtl/u_rx_fifo.sv
// ============================================================================
// Module   : u_rx_fifo
// Brief    : UART receive byte FIFO with first-word-fall-through read port,
//            sticky overflow flag and optional framing-error counter
//            (enabled by defining U_RX_FIFO_ERRCNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module u_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  rec_readyH,
    input  logic [7:0]            rec_dataH,
    input  logic                  recv_error,
    input  logic                  rd_enH,
    input  logic                  ovf_clrH,
`ifdef U_RX_FIFO_ERRCNT_EN
    input  logic                  err_clrH,
    output logic [7:0]            err_count,
`endif
    output logic [7:0]            rd_dataH,
    output logic                  rd_validH,
    output logic                  fullH,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflowH
);

    localparam int                c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  w_wr, w_rd;

    assign rd_validH = (level_q != '0);
    assign fullH     = (level_q == c_DEPTH_LVL);
    assign level     = level_q;
    assign overflowH = ovf_q;
    assign rd_dataH  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign w_rd = rd_enH & rd_validH;
    assign w_wr = rec_readyH & (~fullH | rd_enH);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_wr, w_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Set wins over a coincident clear.
        ovf_d = (rec_readyH & fullH & ~rd_enH) | (ovf_q & ~ovf_clrH);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr && sys_rst_n) mem_q[wr_ptr_q] <= rec_dataH;
    end

`ifdef U_RX_FIFO_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clrH)
            err_cnt_d = 8'd0;
        else if (recv_error && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) err_cnt_q <= 8'd0;
        else            err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    logic unused_recv_error;
    assign unused_recv_error = recv_error;
`endif

endmodule

`default_nettype wire
